gshare_bimodal_predictor: RTL and testbench
===========================================

# gshare_bimodal_predictor

Parametrised, multi-lane direction predictor that replaces the fixed compile-time gshare/bimodal selection with a runtime mode input. It sits between the next-PC stage and the fetch stage. It predicts FETCH_WIDTH consecutive instructions per lookup, one cycle after the lookup is accepted. It keeps a speculative global history register (GHR), returns the history each prediction used as a checkpoint, restores the GHR on misprediction, and clears its pattern table with a one-entry-per-cycle sweep after reset.

## Interface
- FETCH_WIDTH, 2, instructions predicted per lookup (≥1)
- ADDR_WIDTH, 32, PC width
- PC_LSB, 2, byte-offset bits dropped from the PC
- PHT_INDEX_BITS, 10, log2 of pattern history table (PHT) entries
- GHR_BITS, 10, global history length; must be ≤ PHT_INDEX_BITS

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = bimodal, 1 = gshare; sampled in every lookup and update cycle
- lookup_valid  in  1  lookup request
- lookup_pc  in  ADDR_WIDTH  PC of lane 0
- lookup_ready  out  1  lookup accepted when high; low during INIT
- pred_valid  out  1  prediction valid
- pred_taken  out  FETCH_WIDTH  per-lane predicted direction
- pred_ghr  out  GHR_BITS  GHR used for this prediction (checkpoint)
- hist_push  in  1  fetch stage pushes one predicted branch outcome
- hist_taken  in  1  outcome pushed into the GHR
- recover_valid  in  1  misprediction recovery request
- recover_ghr  in  GHR_BITS  checkpoint of the mispredicted branch
- recover_taken  in  1  actual outcome of that branch
- upd_valid  in  1  commit-time counter update
- upd_pc  in  ADDR_WIDTH  PC of the branch being updated
- upd_ghr  in  GHR_BITS  checkpoint of the branch being updated
- upd_taken  in  1  resolved direction

## Operation
- **PHT:** 2^PHT_INDEX_BITS 2-bit saturating counters. A counter predicts taken when its MSB is 1. Counters are not reset by rst_n; the INIT sweep clears them.
- **Lane PC:** lane i uses pc_i = lookup_pc + (i << PC_LSB).
- **Index:**
  - base = pc_i[PC_LSB +: PHT_INDEX_BITS]
  - mode 0: index = base
  - mode 1: index = base XOR zero-extended GHR
  - Updates use the same rule, with upd_pc and upd_ghr in place of the lane PC and GHR.
- **FSM states:**
  - **INIT**, entered on reset: writes 2'b01 (weakly not-taken) to entry init_idx each cycle and increments init_idx. After writing the last entry it moves to READY.
  - **READY:** serves lookups and updates.
  - In INIT, lookups and updates are ignored. GHR pushes and recovery still act.
- **Lookup:** a lookup is accepted when lookup_valid && lookup_ready. In the next cycle the block drives pred_valid=1, pred_taken, and pred_ghr = the GHR value in the accept cycle, taken before any push in that cycle. pred_valid drops the cycle after a cycle with no accept.
- **Update:** counter +1 on taken, −1 on not-taken, saturating at 2'b11 and 2'b00. It is written at the next edge.
- **GHR shift:** GHR ← {GHR[GHR_BITS-2:0], hist_taken} when hist_push is high.
- **Recovery:** GHR ← {recover_ghr[GHR_BITS-2:0], recover_taken} when recover_valid is high. Recovery has priority; a hist_push in the same cycle is dropped.
- **Read/write collision:** a lookup and an update to the same index in the same cycle return the old value (read-before-write).
- **Reset values:**
  - In the INIT state: lookup_ready 0, pred_valid 0, pred_taken 0, pred_ghr 0, GHR 0, init_idx 0.
  - An rst_n assertion at any time, including mid-sweep or in READY, returns the block to these values and restarts the sweep.

## Timing
- Lookup-to-prediction latency: 1 cycle. Throughput: one lookup per cycle.
- INIT lasts exactly 2^PHT_INDEX_BITS cycles after rst_n deasserts. lookup_ready rises in the following cycle.
- GHR and counter changes are visible to lookups accepted in the next cycle or later.
- Pushes and recovery: one each per cycle at most.

## Structure
- **Shared package:** the counter typedef, the weakly-not-taken constant, the mode encoding, and the index hash function.
- **Sub-module:** `pht_init_fsm` (INIT/READY state, init_idx, lookup_ready) is a natural split. The PHT, GHR and update path stay in the top module.

## Test plan
Bench configuration: FETCH_WIDTH=2, PHT_INDEX_BITS=4, GHR_BITS=4.

1. **Reset and init sweep:** release rst_n → lookup_ready stays 0 for 16 cycles and goes to 1 on cycle 17. A lookup at 0x40 then returns pred_taken=2'b00 and pred_ghr=4'b0000.
2. **Bimodal training and saturation:**
   - mode=0; two taken updates at 0x40 → lookup 0x40 gives pred_taken=2'b01.
   - A third taken update, then four not-taken updates → lookup gives 2'b00.
   - A fifth not-taken update, then two taken updates → lookup gives 2'b01, confirming the counter saturated at 00.
3. **Gshare indexing:**
   - mode=1; recover_ghr=4'b0000 with recover_taken=0, then three taken pushes → GHR=4'b0111.
   - Lookup 0x40 → pred_ghr=4'b0111; lanes index entries 0x7 and 0x6.
   - A prior taken update pair at upd_pc=0x40 with upd_ghr=4'b0111 makes pred_taken[0]=1.
4. **Recover plus push in the same cycle:** GHR=4'b0111; recover_ghr=4'b1010 and recover_taken=1 together with hist_push taken → next lookup gives pred_ghr=4'b0101.
5. **Same-index collision:**
   - Entry at 2'b01; lookup and a taken update to that index in the same cycle → pred_taken lane = 0.
   - A second taken update, then a lookup → 1.
6. **Reset mid-operation:** assert rst_n in READY with GHR=4'b1111 → lookup_ready, pred_valid and GHR go to 0 immediately. After release the 16-cycle sweep repeats and the trained entry reads not-taken.

Source files
------------

// File: rtl/gshare_bimodal_predictor_pkg.sv
// Shared types and helpers for the gshare/bimodal direction predictor:
// counter type, reset value, mode/state encodings and the PHT index hash.
package gshare_bimodal_predictor_pkg;

  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_WEAK_NT = 2'b01;

  typedef enum logic { MODE_BIMODAL = 1'b0, MODE_GSHARE = 1'b1 } mode_e;
  typedef enum logic { ST_INIT = 1'b0, ST_READY = 1'b1 } init_state_e;

  // Hash operands are carried at a fixed width; callers zero-extend and truncate.
  localparam int HASH_W = 32;
  typedef logic [HASH_W-1:0] hash_t;

  function automatic hash_t pht_hash(input hash_t base, input hash_t ghr, input mode_e mode);
    return (mode == MODE_GSHARE) ? (base ^ ghr) : base;
  endfunction

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_bimodal_predictor_if.sv
// Lookup, prediction, history and update signals between fetch and the predictor.
interface gshare_bimodal_predictor_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int GHR_BITS    = 10
);
  logic                   mode;
  logic                   lookup_valid;
  logic [ADDR_WIDTH-1:0]  lookup_pc;
  logic                   lookup_ready;
  logic                   pred_valid;
  logic [FETCH_WIDTH-1:0] pred_taken;
  logic [GHR_BITS-1:0]    pred_ghr;
  logic                   hist_push;
  logic                   hist_taken;
  logic                   recover_valid;
  logic [GHR_BITS-1:0]    recover_ghr;
  logic                   recover_taken;
  logic                   upd_valid;
  logic [ADDR_WIDTH-1:0]  upd_pc;
  logic [GHR_BITS-1:0]    upd_ghr;
  logic                   upd_taken;

  modport master (
    output mode, lookup_valid, lookup_pc, hist_push, hist_taken,
           recover_valid, recover_ghr, recover_taken,
           upd_valid, upd_pc, upd_ghr, upd_taken,
    input  lookup_ready, pred_valid, pred_taken, pred_ghr
  );

  modport slave (
    input  mode, lookup_valid, lookup_pc, hist_push, hist_taken,
           recover_valid, recover_ghr, recover_taken,
           upd_valid, upd_pc, upd_ghr, upd_taken,
    output lookup_ready, pred_valid, pred_taken, pred_ghr
  );
endinterface

// File: rtl/gshare_bimodal_predictor_pht_init_fsm.sv
// INIT/READY sequencer: sweeps every PHT entry once after reset, then opens
// the predictor for lookups and updates.
module pht_init_fsm
  import gshare_bimodal_predictor_pkg::*;
#(
  parameter int PHT_INDEX_BITS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      init_we_o,
  output logic [PHT_INDEX_BITS-1:0] init_idx_o,
  output logic                      ready_o
);

  init_state_e               state_q, state_d;
  logic [PHT_INDEX_BITS-1:0] init_idx_q, init_idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == ST_INIT) begin
      init_idx_d = init_idx_q + PHT_INDEX_BITS'(1);
      if (&init_idx_q) state_d = ST_READY;
    end
  end

  always_comb begin
    ready_o    = (state_q == ST_READY);
    init_we_o  = (state_q == ST_INIT);
    init_idx_o = init_idx_q;
  end

endmodule

// File: rtl/gshare_bimodal_predictor.sv
// Multi-lane direction predictor with runtime bimodal/gshare indexing,
// speculative GHR with checkpoint recovery, and post-reset PHT sweep.
module gshare_bimodal_predictor
  import gshare_bimodal_predictor_pkg::*;
#(
  parameter int FETCH_WIDTH    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int PC_LSB         = 2,
  parameter int PHT_INDEX_BITS = 10,
  parameter int GHR_BITS       = 10
) (
  input logic clk,
  input logic rst_n,
  gshare_bimodal_predictor_if.slave bus
);

  localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;
  typedef logic [PHT_INDEX_BITS-1:0] idx_t;

  ctr_t                   pht_q [PHT_ENTRIES];
  logic [GHR_BITS-1:0]    ghr_q, ghr_d;
  logic                   pred_valid_q;
  logic [FETCH_WIDTH-1:0] pred_taken_q, pred_taken_d;
  logic [GHR_BITS-1:0]    pred_ghr_q, pred_ghr_d;
  logic                   ready, init_we, accept;
  idx_t                   init_idx, upd_idx;
  idx_t                   lane_idx [FETCH_WIDTH];

  pht_init_fsm #(.PHT_INDEX_BITS(PHT_INDEX_BITS)) u_init_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_we_o  (init_we),
    .init_idx_o (init_idx),
    .ready_o    (ready)
  );

  assign accept = bus.lookup_valid && ready;

  // Adding i<<PC_LSB never disturbs bits below PC_LSB, so the lane's index
  // field is just the lane-0 field plus i, modulo the table size.
  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    idx_t lane_base;
    assign lane_base   = bus.lookup_pc[PC_LSB +: PHT_INDEX_BITS] + idx_t'(g);
    assign lane_idx[g] = idx_t'(pht_hash(hash_t'(lane_base), hash_t'(ghr_q), mode_e'(bus.mode)));
  end

  assign upd_idx = idx_t'(pht_hash(hash_t'(bus.upd_pc[PC_LSB +: PHT_INDEX_BITS]),
                                   hash_t'(bus.upd_ghr), mode_e'(bus.mode)));

  always_comb begin
    pred_taken_d = pred_taken_q;
    pred_ghr_d   = pred_ghr_q;
    if (accept) begin
      pred_ghr_d = ghr_q;
      for (int i = 0; i < FETCH_WIDTH; i++) pred_taken_d[i] = pht_q[lane_idx[i]][1];
    end
  end

  // Recovery wins over a same-cycle push.
  always_comb begin
    ghr_d = ghr_q;
    if (bus.recover_valid)  ghr_d = {bus.recover_ghr[GHR_BITS-2:0], bus.recover_taken};
    else if (bus.hist_push) ghr_d = {ghr_q[GHR_BITS-2:0], bus.hist_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= '0;
      pred_ghr_q   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= accept;
      pred_taken_q <= pred_taken_d;
      pred_ghr_q   <= pred_ghr_d;
    end
  end

  // Counters carry no reset; the INIT sweep owns the write port until READY.
  always_ff @(posedge clk) begin
    if (init_we)                     pht_q[init_idx] <= CTR_WEAK_NT;
    else if (ready && bus.upd_valid) pht_q[upd_idx]  <= ctr_next(pht_q[upd_idx], bus.upd_taken);
  end

  assign bus.lookup_ready = ready;
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_taken   = pred_taken_q;
  assign bus.pred_ghr     = pred_ghr_q;

endmodule

// File: tb/tb_gshare_bimodal_predictor.sv
// Scoreboard bench: a behavioural predictor model queues expected predictions
// that a negedge monitor pops whenever the DUT presents pred_valid.
module tb_gshare_bimodal_predictor;

  localparam int FW    = 2;
  localparam int PHT_N = 16;

  typedef struct packed {
    logic [FW-1:0] taken;
    logic [3:0]    ghr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  int   m_pht [PHT_N];
  int   m_ghr;
  int   m_cnt;

  gshare_bimodal_predictor_if #(.FETCH_WIDTH(FW), .ADDR_WIDTH(32), .GHR_BITS(4)) bus();

  gshare_bimodal_predictor #(
    .FETCH_WIDTH(FW), .ADDR_WIDTH(32), .PC_LSB(2), .PHT_INDEX_BITS(4), .GHR_BITS(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.pred_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pred_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pred_taken", 32'(bus.pred_taken), 32'(mon_e.taken));
        check("sb_pred_ghr", 32'(bus.pred_ghr), 32'(mon_e.ghr));
      end
    end
  end

  function automatic int model_index(input logic [31:0] pc, input int ghr, input logic mode);
    int base;
    base = int'((pc / 4) % 16);
    return mode ? (base ^ ghr) : base;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic step();
    exp_t        e;
    int          idx;
    logic [31:0] pc_i;
    if (m_cnt >= PHT_N && bus.lookup_valid) begin
      for (int i = 0; i < FW; i++) begin
        pc_i = bus.lookup_pc + 32'(4 * i);
        idx = model_index(pc_i, m_ghr, bus.mode);
        e.taken[i] = (m_pht[idx] >= 2);
      end
      e.ghr = 4'(m_ghr);
      exp_q.push_back(e);
    end
    if (m_cnt >= PHT_N && bus.upd_valid) begin
      idx = model_index(bus.upd_pc, int'(bus.upd_ghr), bus.mode);
      if (bus.upd_taken) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
      else               m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
    end
    if (bus.recover_valid)  m_ghr = (int'(bus.recover_ghr) * 2 + int'(bus.recover_taken)) % 16;
    else if (bus.hist_push) m_ghr = (m_ghr * 2 + int'(bus.hist_taken)) % 16;
    @(posedge clk);
    #1;
    if (m_cnt < PHT_N) m_cnt++;
  endtask

  task automatic idle();
    bus.lookup_valid  = 1'b0;
    bus.lookup_pc     = '0;
    bus.hist_push     = 1'b0;
    bus.hist_taken    = 1'b0;
    bus.recover_valid = 1'b0;
    bus.recover_ghr   = '0;
    bus.recover_taken = 1'b0;
    bus.upd_valid     = 1'b0;
    bus.upd_pc        = '0;
    bus.upd_ghr       = '0;
    bus.upd_taken     = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    idle();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = pc;
    step();
    idle();
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [3:0] ghr, input logic t);
    idle();
    bus.upd_valid = 1'b1;
    bus.upd_pc    = pc;
    bus.upd_ghr   = ghr;
    bus.upd_taken = t;
    step();
    idle();
  endtask

  task automatic do_push(input logic t);
    idle();
    bus.hist_push  = 1'b1;
    bus.hist_taken = t;
    step();
    idle();
  endtask

  // Counts cycles until lookup_ready, with lookups and updates offered
  // throughout so that any leak out of INIT is caught by the scoreboard.
  task automatic sweep_and_count(input string name);
    int n;
    n = 0;
    check({name, "_ready_low"}, 32'(bus.lookup_ready), 32'd0);
    while (bus.lookup_ready !== 1'b1 && n < 100) begin
      idle();
      bus.lookup_valid = 1'b1;
      bus.lookup_pc    = 32'h40;
      bus.upd_valid    = 1'b1;
      bus.upd_pc       = 32'h40;
      bus.upd_taken    = 1'b1;
      step();
      n++;
    end
    idle();
    check({name, "_init_cycles"}, 32'(n), 32'd16);
  endtask

  task automatic check_pred(input string name, input logic [1:0] taken, input logic [3:0] ghr);
    check({name, "_valid"}, 32'(bus.pred_valid), 32'd1);
    check({name, "_taken"}, 32'(bus.pred_taken), 32'(taken));
    check({name, "_ghr"}, 32'(bus.pred_ghr), 32'(ghr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode = 1'b0;
    idle();
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("rst_pred_ghr", 32'(bus.pred_ghr), 32'd0);
    rst_n = 1'b1;

    // 1: sweep then first lookup
    sweep_and_count("t1");
    do_lookup(32'h40);
    check_pred("t1_lookup", 2'b00, 4'b0000);

    // 2: bimodal training and saturation
    bus.mode = 1'b0;
    do_update(32'h40, 4'h0, 1'b1);
    do_update(32'h40, 4'h0, 1'b1);
    do_lookup(32'h40);
    check_pred("t2_two_taken", 2'b01, 4'b0000);
    do_update(32'h40, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) do_update(32'h40, 4'h0, 1'b0);
    do_lookup(32'h40);
    check_pred("t2_four_nt", 2'b00, 4'b0000);
    do_update(32'h40, 4'h0, 1'b0);
    do_update(32'h40, 4'h0, 1'b1);
    do_update(32'h40, 4'h0, 1'b1);
    do_lookup(32'h40);
    check_pred("t2_sat_low", 2'b01, 4'b0000);

    // 3: gshare indexing
    bus.mode = 1'b1;
    do_update(32'h40, 4'b0111, 1'b1);
    do_update(32'h40, 4'b0111, 1'b1);
    idle();
    bus.recover_valid = 1'b1;
    bus.recover_ghr   = 4'b0000;
    bus.recover_taken = 1'b0;
    step();
    for (int i = 0; i < 3; i++) do_push(1'b1);
    do_lookup(32'h40);
    check_pred("t3_gshare", 2'b01, 4'b0111);

    // 4: recovery beats a same-cycle push
    idle();
    bus.recover_valid = 1'b1;
    bus.recover_ghr   = 4'b1010;
    bus.recover_taken = 1'b1;
    bus.hist_push     = 1'b1;
    bus.hist_taken    = 1'b1;
    step();
    do_lookup(32'h40);
    check("t4_recover_ghr", 32'(bus.pred_ghr), 32'h5);

    // 5: lookup and update to the same index in one cycle
    bus.mode = 1'b0;
    idle();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h48;
    bus.upd_valid    = 1'b1;
    bus.upd_pc       = 32'h48;
    bus.upd_taken    = 1'b1;
    step();
    idle();
    check_pred("t5_collide", 2'b00, 4'b0101);
    do_update(32'h48, 4'h0, 1'b1);
    do_lookup(32'h48);
    check_pred("t5_after", 2'b01, 4'b0101);

    // 6: reset while READY with a prediction in flight
    for (int i = 0; i < 4; i++) do_push(1'b1);
    do_lookup(32'h80);
    check("t6_pre_ghr", 32'(bus.pred_ghr), 32'hf);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_ready", 32'(bus.lookup_ready), 32'd0);
    check("t6_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("t6_pred_ghr", 32'(bus.pred_ghr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sweep_and_count("t6");
    do_lookup(32'h40);
    check_pred("t6_retrained", 2'b00, 4'b0000);

    // randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      bus.mode          = 1'($urandom);
      bus.lookup_valid  = ($urandom_range(3) != 0);
      bus.lookup_pc     = $urandom;
      bus.hist_push     = 1'($urandom);
      bus.hist_taken    = 1'($urandom);
      bus.recover_valid = ($urandom_range(7) == 0);
      bus.recover_ghr   = 4'($urandom);
      bus.recover_taken = 1'($urandom);
      bus.upd_valid     = 1'($urandom);
      bus.upd_pc        = $urandom;
      bus.upd_ghr       = 4'($urandom);
      bus.upd_taken     = 1'($urandom);
      step();
    end
    idle();
    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
